// File: rtl/calc3_port_issuer.sv
// calc3_port_issuer: per-port command issuer with 4-entry tag allocation.
// Drives the two-cycle command protocol (opcode + operand 1, then operand 2)
// and forwards port responses as registered completions.
// Optional feature macro: CALC3_TAG_CHECK_EN (drop responses for tags that
// are not outstanding and raise a sticky err_tag).
module calc3_port_issuer #(
   parameter int INSTR_WD = 4,
   parameter int REG_WD   = 32,
   parameter int RSP_WD   = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [INSTR_WD-1:0] req_op,
   input  logic [REG_WD-1:0]   req_d1,
   input  logic [REG_WD-1:0]   req_d2,
   output logic [INSTR_WD-1:0] op,
   output logic [REG_WD-1:0]   data_in,
   output logic [1:0]          tag_in,
   input  logic [RSP_WD-1:0]   resp,
   input  logic [REG_WD-1:0]   data_out,
   input  logic [1:0]          tag_out,
   output logic                cpl_valid,
   output logic [RSP_WD-1:0]   cpl_resp,
   output logic [REG_WD-1:0]   cpl_data,
   output logic [1:0]          cpl_tag,
   output logic                busy,
   output logic                err_tag
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CMD   = 2'd1;
   localparam logic [1:0] ST_OPND2 = 2'd2;

   logic [1:0]        state_p1;
   logic [3:0]        outst_p1;
   logic [REG_WD-1:0] d2_p1;

   logic [1:0] alloc_tag;
   logic       have_free;
   logic       accept;
   logic       issue;
   logic       resp_hit;
   logic       fwd;
   logic [3:0] set_mask;
   logic [3:0] clr_mask;

   // Lowest-numbered free tag, taken from the registered bitmap only so a tag
   // retiring this cycle is not handed out until the next one.
   always_comb begin
      alloc_tag = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!outst_p1[i]) alloc_tag = 2'(i);
      end
   end

   assign have_free = ~&outst_p1;
   assign req_ready = !reset && ((state_p1 == ST_IDLE) || (state_p1 == ST_OPND2)) && have_free;
   assign accept    = req_valid && req_ready;
   assign issue     = accept && (req_op != '0);
   assign resp_hit  = (resp != '0);

`ifdef CALC3_TAG_CHECK_EN
   logic spurious;
   assign fwd      = resp_hit && outst_p1[tag_out];
   assign spurious = resp_hit && !outst_p1[tag_out];
`else
   assign fwd      = resp_hit;
`endif

   assign set_mask = issue ? (4'b0001 << alloc_tag) : 4'b0000;
   assign clr_mask = fwd   ? (4'b0001 << tag_out)   : 4'b0000;
   assign busy     = |outst_p1;

   // Issue FSM; port lines are registered so each state's values appear in
   // the cycle the FSM occupies that state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_p1 <= ST_IDLE;
         op       <= '0;
         data_in  <= '0;
         tag_in   <= 2'd0;
      end else if (issue) begin
         state_p1 <= ST_CMD;
         op       <= req_op;
         data_in  <= req_d1;
         tag_in   <= alloc_tag;
      end else if (state_p1 == ST_CMD) begin
         state_p1 <= ST_OPND2;
         op       <= '0;
         data_in  <= d2_p1;
         tag_in   <= 2'd0;
      end else begin
         state_p1 <= ST_IDLE;
         op       <= '0;
         data_in  <= '0;
         tag_in   <= 2'd0;
      end
   end

   // Operand 2 is parked here until the second protocol beat.
   always_ff @(posedge clock) begin
      if (issue) d2_p1 <= req_d2;
   end

   // Outstanding-tag bitmap: allocation sets, forwarded responses clear.
   always_ff @(posedge clock) begin
      if (reset) outst_p1 <= 4'b0000;
      else       outst_p1 <= (outst_p1 & ~clr_mask) | set_mask;
   end

   // Completion register: strobe for one cycle, payload holds between strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         cpl_valid <= 1'b0;
         cpl_resp  <= '0;
         cpl_data  <= '0;
         cpl_tag   <= 2'd0;
      end else begin
         cpl_valid <= fwd;
         if (fwd) begin
            cpl_resp <= resp;
            cpl_data <= data_out;
            cpl_tag  <= tag_out;
         end
      end
   end

`ifdef CALC3_TAG_CHECK_EN
   // Sticky flag for responses carrying a tag that is not outstanding.
   always_ff @(posedge clock) begin
      if (reset)         err_tag <= 1'b0;
      else if (spurious) err_tag <= 1'b1;
   end
`else
   assign err_tag = 1'b0;
`endif

endmodule

// File: tb/tb_calc3_port_issuer.sv
// Self-checking bench for calc3_port_issuer: reference model with issue and
// completion scoreboards, directed scenarios and a short random phase.
module tb_calc3_port_issuer;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_d1, req_d2;
   logic [3:0]  op;
   logic [31:0] data_in;
   logic [1:0]  tag_in;
   logic [1:0]  resp;
   logic [31:0] data_out;
   logic [1:0]  tag_out;
   logic        cpl_valid;
   logic [1:0]  cpl_resp;
   logic [31:0] cpl_data;
   logic [1:0]  cpl_tag;
   logic        busy;
   logic        err_tag;

   int n_chk = 0;
   int n_err = 0;

   calc3_port_issuer dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_d1(req_d1), .req_d2(req_d2),
      .op(op), .data_in(data_in), .tag_in(tag_in),
      .resp(resp), .data_out(data_out), .tag_out(tag_out),
      .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data), .cpl_tag(cpl_tag),
      .busy(busy), .err_tag(err_tag)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [1:0]  tag;
   } iss_t;

   typedef struct packed {
      logic [1:0]  r;
      logic [31:0] d;
      logic [1:0]  t;
   } cpl_t;

   iss_t exp_iss[$];
   cpl_t exp_cpl[$];

   function automatic logic [1:0] low_free(input logic [3:0] bm);
      logic [1:0] t;
      t = 2'd0;
      for (int i = 3; i >= 0; i--) if (!bm[i]) t = 2'(i);
      return t;
   endfunction

   // Reference model: 0=idle, 1=cmd, 2=opnd2
   logic [3:0] m_bm;
   logic [1:0] m_st;
   logic       m_err;
   cpl_t       m_last;
   wire m_ready = !reset && (m_st != 2'd1) && (m_bm != 4'hF);
   wire m_issue = req_valid && m_ready && (req_op != 4'd0);
   wire m_known = m_bm[tag_out];
`ifdef CALC3_TAG_CHECK_EN
   wire m_fwd = (resp != 2'd0) && m_known;
`else
   wire m_fwd = (resp != 2'd0);
`endif

   always @(posedge clock) begin
      if (reset) begin
         m_bm   <= 4'h0;
         m_st   <= 2'd0;
         m_err  <= 1'b0;
         m_last <= '0;
         exp_iss.delete();
         exp_cpl.delete();
      end else begin
         m_st <= m_issue ? 2'd1 : ((m_st == 2'd1) ? 2'd2 : 2'd0);
         m_bm <= (m_bm & ~(m_fwd ? (4'b0001 << tag_out) : 4'h0))
                 | (m_issue ? (4'b0001 << low_free(m_bm)) : 4'h0);
         if (m_issue) exp_iss.push_back('{req_op, req_d1, req_d2, low_free(m_bm)});
         if (m_fwd) begin
            exp_cpl.push_back('{resp, data_out, tag_out});
            m_last <= '{resp, data_out, tag_out};
         end
`ifdef CALC3_TAG_CHECK_EN
         if ((resp != 2'd0) && !m_known) m_err <= 1'b1;
`endif
      end
   end

   // Per-cycle comparison of every output against the model and scoreboards
   always @(negedge clock) begin
      iss_t e;
      cpl_t c;
      chk("req_ready", req_ready, m_ready);
      chk("busy", busy, |m_bm);
      chk("err_tag", err_tag, m_err);
      case (m_st)
         2'd1: begin
            if (exp_iss.size() == 0) chk("iss_queue", exp_iss.size(), 1);
            else begin
               e = exp_iss[0];
               chk("cmd_op", op, e.op);
               chk("cmd_d1", data_in, e.d1);
               chk("cmd_tag", tag_in, e.tag);
            end
         end
         2'd2: begin
            if (exp_iss.size() == 0) chk("iss_queue", exp_iss.size(), 1);
            else begin
               e = exp_iss.pop_front();
               chk("opnd2_op", op, 0);
               chk("opnd2_d2", data_in, e.d2);
               chk("opnd2_tag", tag_in, 0);
            end
         end
         default: begin
            chk("idle_op", op, 0);
            chk("idle_data", data_in, 0);
            chk("idle_tag", tag_in, 0);
         end
      endcase
      chk("cpl_valid", cpl_valid, exp_cpl.size() != 0);
      if (cpl_valid && exp_cpl.size() != 0) begin
         c = exp_cpl.pop_front();
         chk("cpl_resp", cpl_resp, c.r);
         chk("cpl_data", cpl_data, c.d);
         chk("cpl_tag", cpl_tag, c.t);
      end
      chk("cpl_hold", {cpl_resp, cpl_data, cpl_tag}, m_last);
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_ready(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         if (req_ready) ok = 1'b1;
      end
   endtask

   task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      logic ok;
      req_valid = 1'b1;
      req_op = o; req_d1 = a; req_d2 = b;
      wait_ready(ok);
      chk("send_timeout", ok, 1);
      step();
   endtask

   task automatic respond(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
      resp = r; data_out = d; tag_out = t;
      step();
      resp = 2'd0;
   endtask

   initial begin
      logic ok;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_d1 = 32'd0; req_d2 = 32'd0;
      resp = 2'd0; data_out = 32'd0; tag_out = 2'd0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // Single command followed by its response
      send(4'd1, 32'd5, 32'd7);
      req_valid = 1'b0;
      @(negedge clock);
      chk("t1_op", op, 1); chk("t1_d1", data_in, 5); chk("t1_tag", tag_in, 0);
      @(negedge clock);
      chk("t1_op2", op, 0); chk("t1_d2", data_in, 7);
      @(negedge clock);
      chk("t1_idle", data_in, 0); chk("t1_busy", busy, 1);
      step();
      respond(2'd1, 32'd12, 2'd0);
      @(negedge clock);
      chk("t1_cv", cpl_valid, 1); chk("t1_cd", cpl_data, 12); chk("t1_ct", cpl_tag, 0);
      @(negedge clock);
      chk("t1_free", busy, 0);

      // Five back-to-back commands: fill all tags, fifth waits for tag 2
      step();
      for (int i = 0; i < 4; i++) send(4'(i + 2), 32'(100 + i), 32'(200 + i));
      req_op = 4'd9; req_d1 = 32'd300; req_d2 = 32'd400;
      repeat (3) step();
      @(negedge clock);
      chk("full_ready", req_ready, 0);
      step();
      respond(2'd2, 32'd55, 2'd2);
      wait_ready(ok);
      chk("fifth_timeout", ok, 1);
      step();
      req_valid = 1'b0;
      @(negedge clock);
      chk("fifth_tag", tag_in, 2);

      // Retire tag 1 while full and a request waits: no same-cycle reuse
      step();
      req_valid = 1'b1; req_op = 4'd3; req_d1 = 32'd11; req_d2 = 32'd22;
      resp = 2'd1; data_out = 32'd66; tag_out = 2'd1;
      @(negedge clock);
      chk("retire_same_ready", req_ready, 0);
      step();
      resp = 2'd0;
      wait_ready(ok);
      chk("reuse_timeout", ok, 1);
      step();
      req_valid = 1'b0;
      @(negedge clock);
      chk("reuse_tag", tag_in, 1);

      // Tag 0 free beforehand, tag 1 retiring while accepting: gets tag 0
      respond(2'd3, 32'd77, 2'd0);
      req_valid = 1'b1; req_op = 4'd4; req_d1 = 32'd33; req_d2 = 32'd44;
      resp = 2'd1; data_out = 32'd88; tag_out = 2'd1;
      @(negedge clock);
      chk("sim_ready", req_ready, 1);
      step();
      resp = 2'd0; req_valid = 1'b0;
      @(negedge clock);
      chk("sim_tag", tag_in, 0);
      step();
      send(4'd6, 32'd1, 32'd2);
      req_valid = 1'b0;
      @(negedge clock);
      chk("next_tag", tag_in, 1);
      step();

      // Drain all outstanding tags
      for (int t = 0; t < 4; t++) respond(2'd1, 32'(500 + t), 2'(t));
      step();

      // Zero opcode is consumed without port activity
      send(4'd0, 32'hdead, 32'hbeef);
      req_valid = 1'b0;
      @(negedge clock);
      chk("op0_port", op, 0); chk("op0_data", data_in, 0); chk("op0_busy", busy, 0);
      step();

      // Response for a tag that is not outstanding
      respond(2'd1, 32'd99, 2'd3);
      @(negedge clock);
`ifdef CALC3_TAG_CHECK_EN
      chk("spur_cv", cpl_valid, 0); chk("spur_err", err_tag, 1);
`else
      chk("spur_cv", cpl_valid, 1); chk("spur_tag", cpl_tag, 3); chk("spur_err", err_tag, 0);
`endif
      repeat (3) step();
      @(negedge clock);
`ifdef CALC3_TAG_CHECK_EN
      chk("spur_sticky", err_tag, 1);
`else
      chk("spur_sticky", err_tag, 0);
`endif

      // Reset during OPND2, then a late response on the abandoned tag
      step();
      send(4'd5, 32'd1, 32'd2);
      req_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("rst_op", op, 0); chk("rst_data", data_in, 0); chk("rst_busy", busy, 0);
      chk("rst_cv", cpl_valid, 0); chk("rst_err", err_tag, 0); chk("rst_cd", cpl_data, 0);
      step();
      respond(2'd1, 32'd123, 2'd0);
      @(negedge clock);
`ifdef CALC3_TAG_CHECK_EN
      chk("late_cv", cpl_valid, 0); chk("late_err", err_tag, 1);
`else
      chk("late_cv", cpl_valid, 1); chk("late_tag", cpl_tag, 0);
`endif
      step();

      // Random traffic checked against the model
      for (int i = 0; i < 120; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_op    = 4'($urandom_range(0, 15));
         req_d1    = $urandom;
         req_d2    = $urandom;
         resp      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         data_out  = $urandom;
         tag_out   = 2'($urandom_range(0, 3));
         step();
      end
      req_valid = 1'b0; resp = 2'd0;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/calc3_port_issuer.md
# calc3_port_issuer

Per-port command issuer that sits directly upstream of one calculator port and also collects that port's responses. It accepts two-operand commands over a valid/ready handshake and allocates one of four 2-bit tags. It drives the port's `op`/`data_in`/`tag_in` lines with the two-cycle command protocol (opcode plus operand 1, then operand 2). It retires tags as `resp`/`data_out`/`tag_out` return and presents each completion one cycle later.

## Interface

Parameters:
- `INSTR_WD`, default 4: opcode width (`INSTR_WIDTH`).
- `REG_WD`, default 32: operand/result width (`REGISTER_WIDTH`).
- `RSP_WD`, default 2: response code width (`RESP_WIDTH`).

Ports. One clock (`clock`); reset (`reset`) is synchronous and active-high.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: command offered.
- `req_ready` out 1: issuer can accept this cycle.
- `req_op` in INSTR_WD: opcode.
- `req_d1` in REG_WD: operand 1.
- `req_d2` in REG_WD: operand 2.
- `op` out INSTR_WD: opcode to port.
- `data_in` out REG_WD: operand to port.
- `tag_in` out 2: tag to port.
- `resp` in RSP_WD: response code from port; 0 means none.
- `data_out` in REG_WD: result from port.
- `tag_out` in 2: tag of the response.
- `cpl_valid` out 1: completion strobe.
- `cpl_resp` out RSP_WD: registered copy of `resp`.
- `cpl_data` out REG_WD: registered copy of `data_out`.
- `cpl_tag` out 2: registered copy of `tag_out`.
- `busy` out 1: at least one tag outstanding.
- `err_tag` out 1: sticky spurious-tag error; see Configuration.

## Operation

- Issue FSM states:
  - IDLE: port lines drive 0.
  - CMD: `op`=opcode, `data_in`=operand 1, `tag_in`=tag.
  - OPND2: `op`=0, `data_in`=operand 2, `tag_in`=0.
- `req_ready` = !reset && (state IDLE or OPND2) && (at least one free tag).
  - Combinational from registered state and the outstanding bitmap only.
  - Never depends on `req_valid`.
- On accept (`req_valid && req_ready`) with `req_op != 0`:
  - Allocate the lowest-numbered free tag.
  - Set its outstanding bit.
  - Latch opcode, operands and tag.
  - Next state is CMD.
- On accept with `req_op == 0`: request is consumed and dropped. No tag, no issue; next state is IDLE.
- State transitions:
  - CMD always goes to OPND2.
  - OPND2 goes to CMD on a non-zero accept, otherwise to IDLE.
- Port outputs are registered. Values shown for a state appear during the cycle the FSM is in that state.
- Response capture: in any cycle with `resp != 0`:
  - Clear the outstanding bit `tag_out`.
  - Register `resp`/`data_out`/`tag_out` to `cpl_*` with `cpl_valid`=1 the following cycle.
  - There is no backpressure on completions; the consumer must accept every strobe.
- When `resp == 0`, `cpl_valid`=0 next cycle and `cpl_resp/cpl_data/cpl_tag` hold their last values.
- Simultaneous retire and allocate:
  - A tag retired in cycle t is not allocatable in cycle t; it becomes allocatable from t+1.
  - Allocation uses the registered bitmap only.
- Full: with 4 tags outstanding, `req_ready`=0 until a retirement.
- `busy` = OR of the outstanding bitmap (registered).

## Timing

- Reset values: state IDLE, bitmap 0.
  - `op`=0, `data_in`=0, `tag_in`=0.
  - `cpl_valid`=0, `cpl_resp`=0, `cpl_data`=0, `cpl_tag`=0.
  - `busy`=0, `err_tag`=0, `req_ready`=0 while `reset` is high.
- Accept at edge k: CMD is visible in cycle k+1 and OPND2 in cycle k+2.
- Back-to-back throughput is one command per 2 cycles.
- Response-to-completion latency is 1 cycle. Tag-free latency is 1 cycle.
- Reset mid-operation:
  - The in-flight command is abandoned and the bitmap is cleared.
  - Responses arriving after reset for pre-reset tags are handled as spurious (see Configuration).

## Configuration

- Macro `CALC3_TAG_CHECK_EN`.
- Defined:
  - A response whose `tag_out` is not outstanding is dropped: no `cpl_valid`, bitmap unchanged.
  - `err_tag` is set and stays 1 until reset.
- Undefined: every non-zero `resp` is forwarded to `cpl_*`, and `err_tag` is tied 0.

## Test plan

- Reset, then one request op=1, d1=5, d2=7:
  - `req_ready` is 1 after reset deasserts.
  - Next cycle op=1/data_in=5/tag_in=0, then op=0/data_in=7, then op=0/data_in=0; `busy`=1.
- Response resp=1, data_out=12, tag_out=0: next cycle `cpl_valid`=1, `cpl_data`=12, `cpl_tag`=0; the following cycle `busy`=0.
- Five requests held valid continuously:
  - Tags 0,1,2,3 are issued 2 cycles apart; `req_ready`=0 afterward.
  - After resp on tag 2, tag 2 is accepted one cycle later.
- Response on tag 1 in the same cycle as an accept with tags 0,2,3 outstanding:
  - That accept gets tag 1 only if tag 1 was free beforehand; otherwise `req_ready`=0 that cycle.
  - Tag 1 is issued on the next accept.
- Request with req_op=0: accepted, no port activity, bitmap unchanged.
- With `CALC3_TAG_CHECK_EN`, resp=1 with tag_out=3 while nothing is outstanding: no `cpl_valid`, `err_tag`=1 persistently.
  - Without the macro, the same stimulus gives `cpl_valid`=1, `cpl_tag`=3, `err_tag`=0.
- Reset asserted during OPND2:
  - Next cycle all outputs are 0.
  - A later resp on the old tag behaves as the spurious-tag case above.
